// File: rtl/timeclock_counter_cfg.sv
// Hour:min:sec:centisecond time-of-day counter with tick prescaler, run/stop,
// synchronous clear, validated load, 12/24 h display and second/day strobes.
module timeclock_counter_cfg #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned HOUR_MAX = 24,
  parameter int unsigned DIV_W    = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [5:0] i_load_hour,
  input  logic [5:0] i_load_min,
  input  logic [5:0] i_load_sec,
  input  logic       i_mode_12h,
  output logic [5:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [6:0] o_msec,
  output logic       o_pm,
  output logic       o_sec_tick,
  output logic       o_day_wrap,
  output logic       o_load_err
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [5:0]       HOUR_LAST = 6'(HOUR_MAX - 1);
  localparam logic [6:0]       HOUR_LIM  = 7'(HOUR_MAX);

  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       msec_q, msec_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       hour_q, hour_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_wrap_q, day_wrap_d;
  logic             load_err_q, load_err_d;

  logic tick, load_ok;
  logic msec_wrap, sec_wrap, min_wrap, hour_wrap;

  assign tick      = i_run && (div_q == DIV_LAST);
  assign load_ok   = ({1'b0, i_load_hour} < HOUR_LIM) && (i_load_min < 6'd60) &&
                     (i_load_sec < 6'd60);
  assign msec_wrap = (msec_q == 7'd99);
  assign sec_wrap  = (sec_q == 6'd59);
  assign min_wrap  = (min_q == 6'd59);
  assign hour_wrap = (hour_q == HOUR_LAST);

  always_comb begin
    div_d      = div_q;
    msec_d     = msec_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;
    if (i_clear) begin
      div_d  = '0;
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (i_load) begin
      if (load_ok) begin
        div_d  = '0;
        msec_d = '0;
        sec_d  = i_load_sec;
        min_d  = i_load_min;
        hour_d = i_load_hour;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      // Full carry chain resolves in one cycle so all fields move on the same edge.
      div_d  = '0;
      msec_d = msec_wrap ? 7'd0 : msec_q + 7'd1;
      if (msec_wrap) begin
        sec_tick_d = 1'b1;
        sec_d      = sec_wrap ? 6'd0 : sec_q + 6'd1;
        if (sec_wrap) begin
          min_d = min_wrap ? 6'd0 : min_q + 6'd1;
          if (min_wrap) begin
            hour_d = hour_wrap ? 6'd0 : hour_q + 6'd1;
            if (hour_wrap) day_wrap_d = 1'b1;
          end
        end
      end
    end else if (i_run) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_q      <= '0;
      msec_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      msec_q     <= msec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  logic [5:0] hour_12;
  assign hour_12 = (hour_q == 6'd0)  ? 6'd12 :
                   (hour_q > 6'd12)  ? hour_q - 6'd12 : hour_q;

  assign o_hour     = i_mode_12h ? hour_12 : hour_q;
  assign o_min      = min_q;
  assign o_sec      = sec_q;
  assign o_msec     = msec_q;
  assign o_pm       = (hour_q >= 6'd12);
  assign o_sec_tick = sec_tick_q;
  assign o_day_wrap = day_wrap_q;
  assign o_load_err = load_err_q;

endmodule
